mips_dmem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mips_dmem_responder_if.sv | 21 ++
 rtl/mips_dmem_array.sv | 36 +++
 rtl/mips_dmem_responder.sv | 123 ++++++++++++
 tb/tb_mips_dmem_responder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder.
//   state_e  : responder FSM states (IDLE, BUSY, DONE)
//   op_e     : captured request operation (OP_LOAD, OP_STORE)
//   WORD_W   : memory word / bus width
//   misaligned() : true when a byte address is not word aligned
package mips_mem_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic {OP_LOAD, OP_STORE} op_e;

  function automatic logic misaligned(input logic [WORD_W-1:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/mips_dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline and the responder.
//   master (pipeline) : drives mem_read, mem_write, addr, wdata
//                       receives rdata, stall, done, err
//   slave (responder) : the mirror image
interface mips_dmem_responder_if;
  import mips_mem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              err;

  modport master (output mem_read, mem_write, addr, wdata,
                  input  rdata, stall, done, err);
  modport slave  (input  mem_read, mem_write, addr, wdata,
                  output rdata, stall, done, err);
endinterface

// File: rtl/mips_dmem_array.sv
// Single-port synchronous RAM, DEPTH x WORD_W.
//   clk, rst : clock; synchronous active-high clear of every word and rdata
//   we_i     : write wdata_i into word idx_i at the edge
//   re_i     : load word idx_i into the read register at the edge
//   idx_i    : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, held until the next read
module mips_dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[idx_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mips_dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS.
// Accepts one load/store at a time, holds stall for LATENCY+1 cycles
// (request cycle plus LATENCY busy cycles), then pulses done (and err for
// misaligned or read+write conflicting requests) for one cycle.
//   clk, rst : clock; synchronous active-high reset (aborts any access)
//   bus      : slave side of mips_dmem_responder_if
//              (mem_read, mem_write, addr, wdata in; rdata, stall, done, err out)
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_dmem_responder_if.slave   bus
);
  localparam int CNT_W = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic              req;
  logic              stall;
  logic              done;
  logic              we;
  logic              re;
  logic [WORD_W-1:0] rdata;

  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Address/data captures carry no control meaning, so they are not reset.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    stall   = 1'b0;
    done    = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          // A read+write conflict is resolved as a store.
          op_d    = bus.mem_write ? OP_STORE : OP_LOAD;
          idx_d   = bus.addr[ADDR_W+1:2];
          wdata_d = bus.wdata;
          mis_d   = misaligned(bus.addr);
          err_d   = misaligned(bus.addr) | (bus.mem_read & bus.mem_write);
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          // Misaligned accesses take full latency but touch nothing.
          we = (op_q == OP_STORE) && !mis_q;
          re = (op_q == OP_LOAD)  && !mis_q;
        end
      end
      DONE: begin
        // The pipeline still shows the old request here; it must not be re-accepted.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mips_dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .re_i    (re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign bus.stall = stall;
  assign bus.done  = done;
  assign bus.err   = done & err_q;
  assign bus.rdata = rdata;
endmodule

// File: tb/tb_mips_dmem_responder.sv
module tb_mips_dmem_responder;
  import mips_mem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_dmem_responder_if bus();

  mips_dmem_responder #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .ADDR_W  (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a plain word array plus the last loaded value.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] rdata_m;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    rdata_m = '0;
  endtask

  // Predict the completion, then drive one request and check the stall/done timing.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int unsigned idx;
    logic mis;
    idx = (a / 4) % DEPTH;
    mis = (a % 4) != 0;
    if (wr) begin
      if (!mis) mem_m[idx] = d;
    end else if (!mis) begin
      rdata_m = mem_m[idx];
    end
    e.rdata = rdata_m;
    e.err   = mis | (rd & wr);
    sb.push_back(e);

    @(posedge clk); #1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("stall", 32'(bus.stall), 32'(k <= LAT));
      chk("done", 32'(bus.done), 32'(k == LAT + 1));
      @(posedge clk);
    end
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    chk("stall_after_done", 32'(bus.stall), 0);
    chk("no_reaccept_done", 32'(bus.done), 0);
  endtask

  // Start a store and reset on its completion edge.
  task automatic do_rst_mid(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.addr      = a;
    bus.wdata     = d;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("stall_pre_rst", 32'(bus.stall), 1);
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_write = 1'b0;
    model_reset();
    @(negedge clk);
    chk("stall_after_rst", 32'(bus.stall), 0);
    chk("done_after_rst", 32'(bus.done), 0);
    chk("rdata_after_rst", bus.rdata, 0);
  endtask

  // Monitor: every done pulse consumes exactly one predicted completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("rdata", bus.rdata, e.rdata);
          chk("err", 32'(bus.err), 32'(e.err));
        end
      end else if (bus.err) begin
        chk("err_without_done", 32'(bus.err), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int unsigned r;
    rst = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", bus.rdata, 0);
    chk("reset_stall", 32'(bus.stall), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_err", 32'(bus.err), 0);

    // Directed scenarios.
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 1'b1, 32'h11, 32'h55);
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 1'b1, 32'h100, 32'h00001234);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
    do_rst_mid(32'h20, 32'hCAFEF00D);
    do_req(1'b1, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 1'b1, 32'h8, 32'h77);
    do_req(1'b1, 1'b0, 32'h8, 32'h0);

    // Randomized traffic over a small index set to force reuse and aliasing.
    for (int n = 0; n < 80; n++) begin
      a = 32'((($urandom_range(0, 3) * DEPTH) + $urandom_range(0, 7)) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom;
      r = $urandom_range(0, 19);
      if (r == 0)      do_rst_mid(a & 32'hFFFF_FFFC, d);
      else if (r < 9)  do_req(1'b1, 1'b0, a, d);
      else if (r < 18) do_req(1'b0, 1'b1, a, d);
      else             do_req(1'b1, 1'b1, a, d);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
